core_seq_ctrl: RTL and testbench

- Instruction sequencer for one core. Drives the 20-bit core instruction word through a full attention pass:
  - K/Q memory fill
  - kernel load into the MAC array
  - execute
  - OFIFO drain to PMEM
  - SFP accumulate pass
  - dual-core sum sync
  - SFP divide/write-back pass
- Sits between the host/testbench (start, len, mem_in data source) and core; one instance per core.

---
 rtl/core_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: per-core instruction sequencer for one attention pass.
// Walks K/Q fill, kernel load, execute, OFIFO drain, SFP accumulate,
// dual-core sum sync and SFP divide/write-back, issuing the 20-bit core
// instruction word. All outputs are registered from the current state, so
// the instruction for a state appears one cycle after that state is entered.
// Optional build macro CORE_SEQ_CTRL_PERF_EN adds the stall_cnt output.
module core_seq_ctrl #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 20,
  parameter int pr      = 8,
  parameter int max_len = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  len,
  input  logic        fifo_valid,
  input  logic        sum_rd_vld,
  output logic [19:0] inst,
  output logic        mem_req,
  output logic        busy,
  output logic        done
`ifdef CORE_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  // Address fields in inst are 4 bits wide, which bounds col and max_len.
  if (bw < 1 || pr < 1 || bw_psum < bw || col < 1 || col > 16 ||
      max_len < 1 || max_len > 16) begin : g_param_range
    $error("core_seq_ctrl: parameter out of supported range");
  end

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_KLOAD = 4'd1;
  localparam logic [3:0] S_QLOAD = 4'd2;
  localparam logic [3:0] S_KFEED = 4'd3;
  localparam logic [3:0] S_EXEC  = 4'd4;
  localparam logic [3:0] S_DRAIN = 4'd5;
  localparam logic [3:0] S_OREAD = 4'd6;
  localparam logic [3:0] S_ACC   = 4'd7;
  localparam logic [3:0] S_SYNC  = 4'd8;
  localparam logic [3:0] S_DIV   = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  localparam logic [5:0] K_LAST      = 6'(col - 1);
  localparam logic [5:0] K_FEED_LAST = 6'(col);
  localparam logic [4:0] MAX_LEN     = 5'(max_len);

  // inst bit positions
  localparam int B_SFP_WR  = 19;
  localparam int B_ACC     = 18;
  localparam int B_DIV     = 17;
  localparam int B_OFIFO   = 16;
  localparam int B_EXEC    = 7;
  localparam int B_KLOAD   = 6;
  localparam int B_QMEM_RD = 5;
  localparam int B_QMEM_WR = 4;
  localparam int B_KMEM_RD = 3;
  localparam int B_KMEM_WR = 2;
  localparam int B_PMEM_RD = 1;
  localparam int B_PMEM_WR = 0;

  logic [3:0]  state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic [4:0]  len_q, len_d;
  logic [19:0] inst_d;
  logic        mem_req_d, busy_d, done_d;

  logic [5:0]  len_ext;
  logic [5:0]  len_last;
  logic [5:0]  div_last;
  logic        len_ok;

  assign len_ext  = {1'b0, len_q};
  assign len_last = len_ext - 6'd1;
  assign div_last = {len_q, 1'b0} - 6'd1;
  assign len_ok   = (len != 5'd0) && (len <= MAX_LEN);

  // Next state, counter and next registered outputs from the current state.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    len_d     = len_q;
    inst_d    = '0;
    mem_req_d = 1'b0;
    busy_d    = (state != S_IDLE);
    done_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          cnt_d = '0;
          if (len_ok) begin
            len_d   = len;
            state_d = S_KLOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_KLOAD: begin
        inst_d[B_KMEM_WR] = 1'b1;
        inst_d[15:12]     = cnt[3:0];
        mem_req_d         = 1'b1;
        if (cnt == K_LAST) begin
          state_d = S_QLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      S_QLOAD: begin
        inst_d[B_QMEM_WR] = 1'b1;
        inst_d[15:12]     = cnt[3:0];
        mem_req_d         = 1'b1;
        if (cnt == len_last) begin
          state_d = S_KFEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      S_KFEED: begin
        // Last cycle carries kernel-load only, covering SRAM read latency.
        inst_d[B_KLOAD] = 1'b1;
        if (cnt < K_FEED_LAST) begin
          inst_d[B_KMEM_RD] = 1'b1;
          inst_d[15:12]     = cnt[3:0];
        end
        if (cnt == K_FEED_LAST) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      S_EXEC: begin
        inst_d[B_EXEC] = 1'b1;
        if (cnt < len_ext) begin
          inst_d[B_QMEM_RD] = 1'b1;
          inst_d[15:12]     = cnt[3:0];
        end
        if (cnt == len_ext) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      S_DRAIN: begin
        if (fifo_valid) begin
          state_d = S_OREAD;
          cnt_d   = '0;
        end
      end
      S_OREAD: begin
        // Each valid FIFO word is popped and written to PMEM row cnt.
        if (fifo_valid) begin
          inst_d[B_OFIFO]   = 1'b1;
          inst_d[B_PMEM_WR] = 1'b1;
          inst_d[11:8]      = cnt[3:0];
          if (cnt == len_last) begin
            state_d = S_ACC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 6'd1;
          end
        end
      end
      S_ACC: begin
        // acc trails pmem_rd by one cycle to line up with read data.
        if (cnt < len_ext) begin
          inst_d[B_PMEM_RD] = 1'b1;
          inst_d[11:8]      = cnt[3:0];
        end
        if (cnt != 6'd0) begin
          inst_d[B_ACC] = 1'b1;
        end
        if (cnt == len_ext) begin
          state_d = S_SYNC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      S_SYNC: begin
        if (sum_rd_vld) begin
          state_d = S_DIV;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        // Even cycle reads row cnt/2, odd cycle writes the divided value back.
        inst_d[11:8] = cnt[4:1];
        if (!cnt[0]) begin
          inst_d[B_PMEM_RD] = 1'b1;
        end else begin
          inst_d[B_DIV]     = 1'b1;
          inst_d[B_PMEM_WR] = 1'b1;
          inst_d[B_SFP_WR]  = 1'b1;
        end
        if (cnt == div_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort wins over every transition and suppresses the done pulse.
    if (abort && (state != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      inst_d    = '0;
      mem_req_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State, counter, latched length and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      inst    <= '0;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      len_q   <= len_d;
      inst    <= inst_d;
      mem_req <= mem_req_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef CORE_SEQ_CTRL_PERF_EN
  logic start_acc;
  logic stall_inc;

  assign start_acc = (state == S_IDLE) && start && !abort;
  assign stall_inc = (state == S_DRAIN) || (state == S_SYNC) ||
                     ((state == S_OREAD) && !fifo_valid);

  // Saturating count of cycles spent waiting on the OFIFO or partner core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Testbench for core_seq_ctrl: directed passes with a scoreboard of the
// expected non-idle output words; a monitor pops and compares each one.
`timescale 1ns/1ps
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  len = 5'd0;
  logic        fifo_valid = 1'b1;
  logic        sum_rd_vld = 1'b1;
  logic [19:0] inst;
  logic        mem_req;
  logic        busy;
  logic        done;
`ifdef CORE_SEQ_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [19:0] inst;
    logic        mem_req;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  core_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .len        (len),
    .fifo_valid (fifo_valid),
    .sum_rd_vld (sum_rd_vld),
    .inst       (inst),
    .mem_req    (mem_req),
    .busy       (busy),
    .done       (done)
`ifdef CORE_SEQ_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [19:0] w, input logic m, input logic d);
    exp_t e;
    e.inst = w;
    e.mem_req = m;
    e.done = d;
    exp_q.push_back(e);
  endfunction

  // Expected non-zero output words of one complete pass with len rows (col=8).
  task automatic push_pass(input int l);
    logic [19:0] w;
    for (int a = 0; a < 8; a++) begin
      w = '0; w[2] = 1'b1; w[15:12] = 4'(a); push(w, 1'b1, 1'b0);
    end
    for (int a = 0; a < l; a++) begin
      w = '0; w[4] = 1'b1; w[15:12] = 4'(a); push(w, 1'b1, 1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      w = '0; w[6] = 1'b1; w[3] = 1'b1; w[15:12] = 4'(a); push(w, 1'b0, 1'b0);
    end
    w = '0; w[6] = 1'b1; push(w, 1'b0, 1'b0);
    for (int a = 0; a < l; a++) begin
      w = '0; w[7] = 1'b1; w[5] = 1'b1; w[15:12] = 4'(a); push(w, 1'b0, 1'b0);
    end
    w = '0; w[7] = 1'b1; push(w, 1'b0, 1'b0);
    for (int a = 0; a < l; a++) begin
      w = '0; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(a); push(w, 1'b0, 1'b0);
    end
    for (int c = 0; c <= l; c++) begin
      w = '0;
      if (c < l) begin w[1] = 1'b1; w[11:8] = 4'(c); end
      if (c > 0) w[18] = 1'b1;
      push(w, 1'b0, 1'b0);
    end
    for (int r = 0; r < l; r++) begin
      w = '0; w[1] = 1'b1; w[11:8] = 4'(r); push(w, 1'b0, 1'b0);
      w = '0; w[19] = 1'b1; w[17] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(r); push(w, 1'b0, 1'b0);
    end
    push(20'h0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle with a non-idle output consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en && reset && (inst != 20'h0 || mem_req || done)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got inst=%05h mem_req=%0b done=%0b, expected no output (t=%0t)",
                 inst, mem_req, done, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({inst, mem_req, done} !== mon_e) begin
          n_fail++;
          $display("FAIL sb_word: got inst=%05h mem_req=%0b done=%0b, expected inst=%05h mem_req=%0b done=%0b (t=%0t)",
                   inst, mem_req, done, mon_e.inst, mon_e.mem_req, mon_e.done, $time);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  // Drive start for one sampling edge; k=0 at the negedge after that edge.
  task automatic do_start(input logic [4:0] l, input bit hold);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    if (!hold) start = 1'b0;
    k = 0;
  endtask

  // k is the number of edges after the accepting edge when done is seen.
  task automatic wait_done(input string name, input int exp_k);
    int lim;
    lim = exp_k + 20;
    while (done !== 1'b1 && k < lim) tick();
    check(name, k, exp_k);
  endtask

  task automatic sb_drained(input string name);
    tick();
    tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #2;
    check("rst_inst", inst, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of EXEC, then a clean len=8 pass
    do_start(5'd8, 1'b0);
    while (k < 30) tick();
    check("exec_word_before_rst", inst, 32'h040A0);
    #2 reset = 1'b0;
    #1;
    check("midrst_inst", inst, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    push_pass(8);
    do_start(5'd8, 1'b0);
    wait_done("done_lat_len8", 70);
    sb_drained("sb_empty_len8");

    // Stall-free len=4 pass: 2*8 + 6*4 + 6 = 46
    push_pass(4);
    do_start(5'd4, 1'b0);
    tick();
    check("busy_after_start", busy, 1);
    wait_done("done_lat_len4", 46);
    check("busy_with_done", busy, 1);
    sb_drained("sb_empty_len4");
    check("idle_after_pass", busy, 0);

    // len=2, OREAD sees fifo_valid 1,0,0,1
    push_pass(2);
    do_start(5'd2, 1'b0);
    while (k < 24) tick();
    check("oread_wr0", inst, 32'h10001);
    fifo_valid = 1'b0;
    tick();
    check("oread_stall0", inst, 0);
    tick();
    check("oread_stall1", inst, 0);
    fifo_valid = 1'b1;
    tick();
    check("oread_wr1", inst, 32'h10101);
    wait_done("done_lat_len2_stall", 36);
`ifdef CORE_SEQ_CTRL_PERF_EN
    check("stall_cnt_len2", stall_cnt, 4);
`endif
    sb_drained("sb_empty_len2");

    // len=1 pass with sum_rd_vld low for 10 SYNC cycles
    sum_rd_vld = 1'b0;
    push_pass(1);
    do_start(5'd1, 1'b0);
    while (k < 24) tick();
    for (int j = 25; j <= 35; j++) begin
      tick();
      check("sync_inst_idle", inst, 0);
      check("sync_busy", busy, 1);
      if (k == 34) sum_rd_vld = 1'b1;
    end
    tick();
    check("div_first_read", inst, 32'h00002);
    wait_done("done_lat_sync_hold", 38);
    sb_drained("sb_empty_sync");

    // Out-of-range lengths go straight to DONE
    push(20'h0, 1'b0, 1'b1);
    do_start(5'd0, 1'b0);
    wait_done("done_lat_len0", 1);
    check("len0_busy_in_done", busy, 1);
    tick();
    check("len0_idle", busy, 0);
    push(20'h0, 1'b0, 1'b1);
    do_start(5'd17, 1'b0);
    wait_done("done_lat_len17", 1);
    sb_drained("sb_empty_badlen");

    // Abort in QLOAD at cnt=2 with start held high
    for (int a = 0; a < 8; a++) push({4'(a), 12'h004}, 1'b1, 1'b0);
    push(20'h00010, 1'b1, 1'b0);
    push(20'h01010, 1'b1, 1'b0);
    do_start(5'd4, 1'b1);
    while (k < 10) tick();
    abort = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_inst", inst, 0);
    abort = 1'b0;
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("abort_stays_idle", {busy, done, mem_req}, 0);
    end
    check("sb_empty_abort", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
